// File: rtl/data_mem_access_controller.sv
// MEM-stage data memory sequencer.
// Takes one load or store from the pipeline, holds the pipeline while the
// request/response handshake with the data memory runs, and returns the
// extended load result for write-back. Misaligned accesses are rejected in
// the cycle they are presented and never reach memory.
module data_mem_access_controller #(
  parameter int XLEN      = 32,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 MemEn,
  input  logic                 MemWrite,
  input  logic [2:0]           TruncSrc,
  input  logic [XLEN-1:0]      Address,
  input  logic [XLEN-1:0]      StoreData,
  output logic                 Stall,
  output logic [XLEN-1:0]      LoadData,
  output logic                 LoadValid,
  output logic                 Misaligned,
  output logic [CNT_WIDTH-1:0] StallCount,
  output logic                 DMemReq,
  output logic                 DMemWe,
  output logic [XLEN-1:0]      DMemAddr,
  output logic [XLEN-1:0]      DMemWData,
  output logic [XLEN/8-1:0]    DMemStrb,
  input  logic                 DMemGnt,
  input  logic                 DMemRValid,
  input  logic [XLEN-1:0]      DMemRData
);

  localparam int NB = XLEN / 8;

  // truncSrc encodings; NONE (5) and anything above it are not memory accesses
  localparam logic [2:0] TS_BYTE   = 3'd0;
  localparam logic [2:0] TS_HALF   = 3'd1;
  localparam logic [2:0] TS_WORD   = 3'd2;
  localparam logic [2:0] TS_BYTE_U = 3'd3;
  localparam logic [2:0] TS_HALF_U = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t                 state_r;
  logic [XLEN-1:0]        addr_r;
  logic [1:0]             off_r;
  logic                   we_r;
  logic [NB-1:0]          strb_r;
  logic [XLEN-1:0]        wdata_r;
  logic [2:0]             size_r;
  logic [XLEN-1:0]        load_data_r;
  logic                   load_valid_r;
  logic                   req_r;
  logic [CNT_WIDTH-1:0]   stall_count_r;

  logic                   size_legal_s;
  logic                   misalign_s;
  logic                   accept_s;
  logic                   reject_s;
  logic                   stall_s;

  // Halfwords need an even address, words a 4-byte aligned one; bytes always fit.
  function automatic logic is_misaligned(input logic [2:0] size, input logic [1:0] off);
    logic mis;
    case (size)
      TS_HALF, TS_HALF_U: mis = off[0];
      TS_WORD:            mis = (off != 2'b00);
      default:            mis = 1'b0;
    endcase
    return mis;
  endfunction

  // Byte strobes for a store; unsigned sizes write exactly like signed ones.
  function automatic logic [NB-1:0] store_strb(input logic [2:0] size, input logic [1:0] off);
    logic [NB-1:0] strb;
    case (size)
      TS_BYTE, TS_BYTE_U: strb = {{(NB-1){1'b0}}, 1'b1} << off;
      TS_HALF, TS_HALF_U: strb = {{(NB-2){1'b0}}, 2'b11} << off;
      default:            strb = {NB{1'b1}};
    endcase
    return strb;
  endfunction

  // Replicate the low store bytes across every lane so the strobes pick the right one.
  function automatic logic [XLEN-1:0] store_wdata(input logic [2:0] size, input logic [XLEN-1:0] sd);
    logic [XLEN-1:0] wd;
    case (size)
      TS_BYTE, TS_BYTE_U: wd = {NB{sd[7:0]}};
      TS_HALF, TS_HALF_U: wd = {(NB/2){sd[15:0]}};
      default:            wd = sd;
    endcase
    return wd;
  endfunction

  // Shift the addressed lane down and sign- or zero-extend it to XLEN.
  function automatic logic [XLEN-1:0] load_extend(input logic [2:0] size, input logic [1:0] off,
                                                  input logic [XLEN-1:0] rdata);
    logic [XLEN-1:0] lane;
    logic [XLEN-1:0] res;
    lane = rdata >> {off, 3'b000};
    case (size)
      TS_BYTE:   res = {{(XLEN-8){lane[7]}}, lane[7:0]};
      TS_BYTE_U: res = {{(XLEN-8){1'b0}}, lane[7:0]};
      TS_HALF:   res = {{(XLEN-16){lane[15]}}, lane[15:0]};
      TS_HALF_U: res = {{(XLEN-16){1'b0}}, lane[15:0]};
      default:   res = lane;
    endcase
    return res;
  endfunction

  // Classify the incoming MEM-stage request and derive the pipeline stall.
  always_comb begin
    size_legal_s = (TruncSrc <= TS_HALF_U);
    misalign_s   = is_misaligned(TruncSrc, Address[1:0]);
    accept_s     = 1'b0;
    reject_s     = 1'b0;
    if ((state_r == ST_IDLE) && MemEn && size_legal_s) begin
      if (misalign_s) begin
        reject_s = 1'b1;
      end else begin
        accept_s = 1'b1;
      end
    end else begin
      accept_s = 1'b0;
      reject_s = 1'b0;
    end
    stall_s = accept_s || (state_r == ST_REQ) || (state_r == ST_WAIT);
  end

  // Access sequencer: latch the request, hold it until granted, catch the read data.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r      <= ST_IDLE;
      addr_r       <= '0;
      off_r        <= 2'b00;
      we_r         <= 1'b0;
      strb_r       <= '0;
      wdata_r      <= '0;
      size_r       <= 3'd0;
      load_data_r  <= '0;
      load_valid_r <= 1'b0;
      req_r        <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          load_valid_r <= 1'b0;
          req_r        <= 1'b0;
          if (accept_s) begin
            addr_r  <= {Address[XLEN-1:2], 2'b00};
            off_r   <= Address[1:0];
            we_r    <= MemWrite;
            strb_r  <= MemWrite ? store_strb(TruncSrc, Address[1:0]) : '0;
            wdata_r <= store_wdata(TruncSrc, StoreData);
            size_r  <= TruncSrc;
            req_r   <= 1'b1;
            state_r <= ST_REQ;
          end
        end
        ST_REQ: begin
          // A read response arriving together with the grant is not ours yet.
          if (DMemGnt) begin
            req_r   <= 1'b0;
            state_r <= we_r ? ST_DONE : ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (DMemRValid) begin
            load_data_r  <= load_extend(size_r, off_r, DMemRData);
            load_valid_r <= 1'b1;
            state_r      <= ST_DONE;
          end
        end
        ST_DONE: begin
          load_valid_r <= 1'b0;
          state_r      <= ST_IDLE;
        end
        default: begin
          load_valid_r <= 1'b0;
          req_r        <= 1'b0;
          state_r      <= ST_IDLE;
        end
      endcase
    end
  end

  // Count every cycle the pipeline is held, sticking at all-ones.
  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_count_r <= '0;
    end else if (stall_s && (stall_count_r != {CNT_WIDTH{1'b1}})) begin
      stall_count_r <= stall_count_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      stall_count_r <= stall_count_r;
    end
  end

  assign Stall      = stall_s;
  assign Misaligned = reject_s;
  assign LoadData   = load_data_r;
  assign LoadValid  = load_valid_r;
  assign StallCount = stall_count_r;
  assign DMemReq    = req_r;
  assign DMemWe     = we_r;
  assign DMemAddr   = addr_r;
  assign DMemWData  = wdata_r;
  assign DMemStrb   = strb_r;

endmodule

// File: tb/tb_data_mem_access_controller.sv
// Scoreboard bench for data_mem_access_controller: the driver pushes the
// expected memory request / load result / rejection, and a negedge monitor
// pops and compares whenever the DUT presents one of those outputs.
module tb_data_mem_access_controller;

  localparam int K_REQ  = 0;
  localparam int K_LOAD = 1;
  localparam int K_MIS  = 2;

  typedef struct {
    int          kind;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  strb;
    logic [31:0] wdata;
    logic [31:0] data;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        MemEn;
  logic        MemWrite;
  logic [2:0]  TruncSrc;
  logic [31:0] Address;
  logic [31:0] StoreData;
  logic        Stall;
  logic [31:0] LoadData;
  logic        LoadValid;
  logic        Misaligned;
  logic [31:0] StallCount;
  logic        DMemReq;
  logic        DMemWe;
  logic [31:0] DMemAddr;
  logic [31:0] DMemWData;
  logic [3:0]  DMemStrb;
  logic        DMemGnt;
  logic        DMemRValid;
  logic [31:0] DMemRData;

  exp_t        sb[$];
  int          n_cmp;
  int          n_bad;
  int          stall_seen;
  int          req_seen;
  logic [31:0] exp_cnt;

  data_mem_access_controller #(.XLEN(32), .CNT_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .MemEn(MemEn), .MemWrite(MemWrite),
    .TruncSrc(TruncSrc), .Address(Address), .StoreData(StoreData),
    .Stall(Stall), .LoadData(LoadData), .LoadValid(LoadValid),
    .Misaligned(Misaligned), .StallCount(StallCount),
    .DMemReq(DMemReq), .DMemWe(DMemWe), .DMemAddr(DMemAddr),
    .DMemWData(DMemWData), .DMemStrb(DMemStrb), .DMemGnt(DMemGnt),
    .DMemRValid(DMemRValid), .DMemRData(DMemRData)
  );

  // free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: DUT output with no matching expectation (queue size %0d)", name, sb.size());
  endtask

  // monitor: compare DUT output events against the scoreboard queue
  always @(negedge clk) begin
    if (reset) begin
      if (Stall) stall_seen++;
      if (Misaligned) begin
        if (sb.size() == 0 || sb[0].kind != K_MIS) unexpected("misaligned_evt");
        else begin
          check32("mis_kind", 32'(sb[0].kind), 32'(K_MIS));
          void'(sb.pop_front());
        end
      end
      if (DMemReq) begin
        req_seen++;
        if (sb.size() == 0 || sb[0].kind != K_REQ) unexpected("dmemreq_evt");
        else begin
          check32("req_addr", DMemAddr, sb[0].addr);
          check32("req_we", 32'(DMemWe), 32'(sb[0].we));
          check32("req_strb", 32'(DMemStrb), 32'(sb[0].strb));
          if (sb[0].we) check32("req_wdata", DMemWData, sb[0].wdata);
          if (DMemGnt) void'(sb.pop_front());
        end
      end
      if (LoadValid) begin
        if (sb.size() == 0 || sb[0].kind != K_LOAD) unexpected("loadvalid_evt");
        else begin
          check32("load_data", LoadData, sb[0].data);
          void'(sb.pop_front());
        end
      end
    end
  end

  task automatic push_exp(input int kind, input logic [31:0] addr, input logic we,
                          input logic [3:0] strb, input logic [31:0] wdata, input logic [31:0] data);
    exp_t e;
    e.kind = kind; e.addr = addr; e.we = we; e.strb = strb; e.wdata = wdata; e.data = data;
    sb.push_back(e);
  endtask

  // one legal access; called at posedge+1 with the DUT idle
  task automatic do_access(input string name, input logic we, input logic [2:0] ts,
                           input logic [31:0] addr, input logic [31:0] sd, input logic [31:0] rdata,
                           input int gnt_dly, input int rv_dly, input logic early_rv,
                           input logic [31:0] exp_addr, input logic [3:0] exp_strb,
                           input logic [31:0] exp_wdata, input logic [31:0] exp_ld);
    int exp_stall;
    push_exp(K_REQ, exp_addr, we, exp_strb, exp_wdata, 32'd0);
    if (!we) push_exp(K_LOAD, 32'd0, 1'b0, 4'd0, 32'd0, exp_ld);
    exp_stall = we ? (2 + gnt_dly) : (3 + gnt_dly + rv_dly);
    stall_seen = 0;
    req_seen = 0;
    MemEn = 1'b1; MemWrite = we; TruncSrc = ts; Address = addr; StoreData = sd;
    @(posedge clk); #1;
    MemEn = 1'b0;
    repeat (gnt_dly) begin @(posedge clk); #1; end
    DMemGnt = 1'b1;
    DMemRValid = early_rv;
    DMemRData = 32'h1111_1111;
    @(posedge clk); #1;
    DMemGnt = 1'b0;
    DMemRValid = 1'b0;
    if (!we) begin
      repeat (rv_dly) begin @(posedge clk); #1; end
      DMemRValid = 1'b1;
      DMemRData = rdata;
      @(posedge clk); #1;
      DMemRValid = 1'b0;
    end
    @(posedge clk); #1;
    exp_cnt = exp_cnt + 32'(exp_stall);
    check32({name, "_stall_cycles"}, 32'(stall_seen), 32'(exp_stall));
    check32({name, "_req_cycles"}, 32'(req_seen), 32'(gnt_dly + 1));
    check32({name, "_stallcount"}, StallCount, exp_cnt);
    check32({name, "_stall_idle"}, 32'(Stall), 32'd0);
  endtask

  // an access that must be rejected (misaligned) or ignored (non-memory truncSrc)
  task automatic do_reject(input string name, input logic we, input logic [2:0] ts,
                           input logic [31:0] addr, input logic exp_mis);
    if (exp_mis) push_exp(K_MIS, 32'd0, 1'b0, 4'd0, 32'd0, 32'd0);
    stall_seen = 0;
    req_seen = 0;
    MemEn = 1'b1; MemWrite = we; TruncSrc = ts; Address = addr; StoreData = 32'hCAFE_F00D;
    @(negedge clk);
    check32({name, "_misaligned"}, 32'(Misaligned), 32'(exp_mis));
    check32({name, "_stall"}, 32'(Stall), 32'd0);
    @(posedge clk); #1;
    MemEn = 1'b0;
    @(posedge clk); #1;
    check32({name, "_no_req"}, 32'(req_seen), 32'd0);
    check32({name, "_stallcount"}, StallCount, exp_cnt);
  endtask

  // directed stimulus
  initial begin
    n_cmp = 0; n_bad = 0; stall_seen = 0; req_seen = 0; exp_cnt = 32'd0;
    reset = 1'b0; MemEn = 1'b0; MemWrite = 1'b0; TruncSrc = 3'd5;
    Address = 32'd0; StoreData = 32'd0;
    DMemGnt = 1'b0; DMemRValid = 1'b0; DMemRData = 32'd0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check32("rst_stall", 32'(Stall), 32'd0);
    check32("rst_loadvalid", 32'(LoadValid), 32'd0);
    check32("rst_loaddata", LoadData, 32'd0);
    check32("rst_dmemreq", 32'(DMemReq), 32'd0);
    check32("rst_dmemaddr", DMemAddr, 32'd0);
    check32("rst_dmemstrb", 32'(DMemStrb), 32'd0);
    check32("rst_stallcount", StallCount, 32'd0);
    @(posedge clk); #1;

    //        name       we    ts    addr          sd            rdata         g  r  early  exp_addr      strb     wdata         load
    do_access("ld_b",    1'b0, 3'd0, 32'h0000_0103, 32'h0,        32'h80FF_1234, 0, 0, 1'b0, 32'h0000_0100, 4'b0000, 32'h0,        32'hFFFF_FF80);
    do_access("ld_hu",   1'b0, 3'd4, 32'h0000_0202, 32'h0,        32'h9ABC_0000, 1, 2, 1'b0, 32'h0000_0200, 4'b0000, 32'h0,        32'h0000_9ABC);
    do_access("st_h",    1'b1, 3'd1, 32'h0000_0012, 32'h1234_ABCD, 32'h0,        0, 0, 1'b0, 32'h0000_0010, 4'b1100, 32'hABCD_ABCD, 32'h0);
    do_access("st_b",    1'b1, 3'd0, 32'h0000_0021, 32'h0000_00A5, 32'h0,        1, 0, 1'b0, 32'h0000_0020, 4'b0010, 32'hA5A5_A5A5, 32'h0);
    do_access("st_bu",   1'b1, 3'd3, 32'h0000_0033, 32'h0000_0077, 32'h0,        0, 0, 1'b0, 32'h0000_0030, 4'b1000, 32'h7777_7777, 32'h0);
    do_access("ld_bu",   1'b0, 3'd3, 32'h0000_0101, 32'h0,        32'h1234_F600, 0, 1, 1'b0, 32'h0000_0100, 4'b0000, 32'h0,        32'h0000_00F6);
    do_access("ld_h",    1'b0, 3'd1, 32'h0000_0300, 32'h0,        32'h0000_C001, 0, 0, 1'b0, 32'h0000_0300, 4'b0000, 32'h0,        32'hFFFF_C001);
    do_access("ld_w",    1'b0, 3'd2, 32'h0000_0404, 32'h0,        32'h89AB_CDEF, 2, 0, 1'b0, 32'h0000_0404, 4'b0000, 32'h0,        32'h89AB_CDEF);
    do_access("ld_early",1'b0, 3'd0, 32'h0000_0000, 32'h0,        32'h0000_00FF, 0, 0, 1'b1, 32'h0000_0000, 4'b0000, 32'h0,        32'hFFFF_FFFF);

    do_reject("mis_ldw",  1'b0, 3'd2, 32'h0000_0006, 1'b1);
    do_reject("mis_sth",  1'b1, 3'd1, 32'h0000_0051, 1'b1);
    do_reject("mis_lhu",  1'b0, 3'd4, 32'h0000_0003, 1'b1);
    do_reject("ign_none", 1'b0, 3'd5, 32'h0000_0006, 1'b0);
    do_reject("ign_7",    1'b1, 3'd7, 32'h0000_0001, 1'b0);

    // reset held low for two edges while a load waits for its data
    push_exp(K_REQ, 32'h0000_0080, 1'b0, 4'b0000, 32'h0, 32'h0);
    MemEn = 1'b1; MemWrite = 1'b0; TruncSrc = 3'd2; Address = 32'h0000_0080;
    @(posedge clk); #1;
    MemEn = 1'b0;
    DMemGnt = 1'b1;
    @(posedge clk); #1;
    DMemGnt = 1'b0;
    reset = 1'b0;
    sb.delete();
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check32("rstw_stall", 32'(Stall), 32'd0);
    check32("rstw_loadvalid", 32'(LoadValid), 32'd0);
    check32("rstw_stallcount", StallCount, 32'd0);
    check32("rstw_dmemreq", 32'(DMemReq), 32'd0);
    exp_cnt = 32'd0;
    // stray read data in IDLE must not produce a load result
    @(posedge clk); #1;
    DMemRValid = 1'b1; DMemRData = 32'h5555_5555;
    @(posedge clk); #1;
    DMemRValid = 1'b0;
    @(posedge clk); #1;
    check32("idle_rvalid_count", StallCount, 32'd0);

    // store word with the grant held off for three cycles
    do_access("st_w_dly", 1'b1, 3'd2, 32'h0000_0040, 32'hDEAD_BEEF, 32'h0, 3, 0, 1'b0,
              32'h0000_0040, 4'b1111, 32'hDEAD_BEEF, 32'h0);
    check32("st_w_dly_count5", StallCount, 32'd5);

    repeat (2) @(posedge clk);
    check32("sb_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // watchdog so a broken DUT can never hang the run
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, %0d compared so far", n_cmp);
    $fatal(1, "watchdog expired");
  end

endmodule
